// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle shared by each requester port and the MemorySystem CPU port.
// The requester drives the request fields; the responder returns hit/err/rdata.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  valid;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W-1:0]     data;
  logic                  wen;
  logic [DATA_W/8-1:0]   strobe;
  logic                  hit;
  logic                  err;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output valid, address, data, wen, strobe,
    input  hit, err, rdata
  );

  modport slave (
    input  valid, address, data, wen, strobe,
    output hit, err, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin, single-outstanding arbiter sharing the MemorySystem CPU request port
// between instruction fetch (p0) and load/store (p1), with a transaction watchdog.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   p0,
  mem_port_arbiter_if.slave   p1,
  mem_port_arbiter_if.master  mem,
  output logic                grant,
  output logic                busy,
  output logic                timeout_flag
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned CntW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_q, grant_d;
  logic                busy_q, busy_d;
  logic                tflag_q, tflag_d;
  logic                mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;
  logic                mem_wen_q, mem_wen_d;
  logic [StrbW-1:0]    mem_strobe_q, mem_strobe_d;
  logic [1:0]          hit_q, hit_d;
  logic [1:0]          err_q, err_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic                pg_valid;
  logic                wdog_expired;
  logic                g;

  assign pg_valid     = grant_q ? p1.valid : p0.valid;
  assign wdog_expired = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    tflag_d      = tflag_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_wen_d    = mem_wen_q;
    mem_strobe_d = mem_strobe_q;
    hit_d        = 2'b00;
    err_d        = 2'b00;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    cnt_d        = cnt_q;
    g            = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (p0.valid || p1.valid) begin
          // On a tie the port that did not win last time goes first.
          g            = (p0.valid && p1.valid) ? ~last_grant_q : p1.valid;
          grant_d      = g;
          last_grant_d = g;
          mem_valid_d  = 1'b1;
          mem_addr_d   = g ? p1.address : p0.address;
          mem_data_d   = g ? p1.data    : p0.data;
          mem_wen_d    = g ? p1.wen     : p0.wen;
          mem_strobe_d = g ? p1.strobe  : p0.strobe;
          cnt_d        = '0;
          state_d      = StBusy;
        end
      end
      StBusy: begin
        if (mem.hit) begin
          hit_d[grant_q] = 1'b1;
          if (grant_q) rdata1_d = mem.rdata;
          else         rdata0_d = mem.rdata;
          mem_valid_d    = 1'b0;
          state_d        = StRelease;
        end else if (wdog_expired) begin
          err_d[grant_q] = 1'b1;
          tflag_d        = 1'b1;
          mem_valid_d    = 1'b0;
          state_d        = StRelease;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelease: begin
        // Wait for the granted requester to drop its stale valid.
        if (!mem.hit && !pg_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StBusy);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      busy_q       <= 1'b0;
      tflag_q      <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_wen_q    <= 1'b0;
      mem_strobe_q <= '0;
      hit_q        <= 2'b00;
      err_q        <= 2'b00;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      tflag_q      <= tflag_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_wen_q    <= mem_wen_d;
      mem_strobe_q <= mem_strobe_d;
      hit_q        <= hit_d;
      err_q        <= err_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      cnt_q        <= cnt_d;
    end
  end

  assign p0.hit       = hit_q[0];
  assign p0.err       = err_q[0];
  assign p0.rdata     = rdata0_q;
  assign p1.hit       = hit_q[1];
  assign p1.err       = err_q[1];
  assign p1.rdata     = rdata1_q;

  assign mem.valid    = mem_valid_q;
  assign mem.address  = mem_addr_q;
  assign mem.data     = mem_data_q;
  assign mem.wen      = mem_wen_q;
  assign mem.strobe   = mem_strobe_q;

  assign grant        = grant_q;
  assign busy         = busy_q;
  assign timeout_flag = tflag_q;

endmodule
